// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit framer: flag, zero-stuffed payload + FCS-16, flag or abort, one registered line bit per clock.
// Latency: first flag bit on Tx one edge after the start is sampled; no backpressure, buffer read runs ahead of the shifter.
module hdlc_tx_sequencer #(
   parameter int MAX_FRAME = 128
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tx_Enable,
   input  logic       Tx_AbortFrame,
   input  logic [7:0] Tx_FrameSize,
   output logic [6:0] Tx_RdAddr,
   input  logic [7:0] Tx_RdData,
   output logic       Tx,
   output logic       Tx_ValidFrame,
   output logic       Tx_AbortedTrans,
   output logic       Tx_Busy,
   output logic       Tx_Done,
   output logic       Tx_SizeErr
);

   typedef enum logic [2:0] {S_IDLE, S_OPEN, S_DATA, S_FCS, S_CLOSE, S_ABORT} state_t;

   localparam logic [7:0] FLAG  = 8'h7E;
   localparam logic [8:0] MAX_N = 9'(MAX_FRAME);

   state_t      r_state, w_state;
   logic [4:0]  r_cnt, w_cnt;
   logic [7:0]  r_sh, w_sh;
   logic [15:0] r_fcs, w_fcs;
   logic [2:0]  r_ones, w_ones;
   logic [7:0]  r_len, w_len;
   logic [7:0]  r_byte, w_byte;
   logic [6:0]  r_addr, w_addr;
   logic        r_tx, r_valid, r_abt, r_busy, r_done, r_close_end, r_size_err;
   logic        w_bit, w_valid, w_abt, w_busy, w_close_end, w_size_err;
   logic [15:0] w_crc;

   assign w_crc = {1'b0, r_fcs[15:1]} ^ ((r_fcs[0] ^ r_sh[0]) ? 16'h8408 : 16'h0000);

   always_ff @(posedge Clk) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_state;
   end

   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_sh        = r_sh;
      w_fcs       = r_fcs;
      w_ones      = r_ones;
      w_len       = r_len;
      w_byte      = r_byte;
      w_addr      = r_addr;
      w_bit       = 1'b1;
      w_valid     = 1'b0;
      w_abt       = 1'b0;
      w_busy      = 1'b0;
      w_close_end = 1'b0;
      w_size_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // r_close_end marks the last-flag cycle; a start is taken from the Tx_Done cycle on
            if (Tx_Enable && !r_close_end) begin
               if (Tx_FrameSize != 8'd0 && {1'b0, Tx_FrameSize} <= MAX_N) begin
                  w_state = S_OPEN;
                  w_len   = Tx_FrameSize;
                  w_addr  = 7'd0;
                  w_fcs   = 16'hFFFF;
                  w_cnt   = 5'd0;
               end else begin
                  w_size_err = 1'b1;
               end
            end
         end
         S_OPEN: begin
            w_busy = 1'b1;
            w_bit  = FLAG[r_cnt[2:0]];
            w_cnt  = r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
               w_state = S_DATA;
               w_cnt   = 5'd0;
               w_sh    = Tx_RdData;
               w_addr  = r_addr + 7'd1;
               w_byte  = 8'd0;
               w_ones  = 3'd0;
            end
         end
         S_DATA: begin
            w_busy  = 1'b1;
            w_valid = 1'b1;
            if (r_ones == 3'd5) begin
               w_bit  = 1'b0;
               w_ones = 3'd0;
            end else begin
               w_bit  = r_sh[0];
               w_sh   = {1'b0, r_sh[7:1]};
               w_fcs  = w_crc;
               w_ones = r_sh[0] ? r_ones + 3'd1 : 3'd0;
               w_cnt  = r_cnt + 5'd1;
               if (r_cnt == 5'd7) begin
                  w_cnt = 5'd0;
                  if (r_byte == r_len - 8'd1) begin
                     w_state = S_FCS;
                  end else begin
                     w_sh   = Tx_RdData;
                     w_addr = r_addr + 7'd1;
                     w_byte = r_byte + 8'd1;
                  end
               end
            end
         end
         S_FCS: begin
            w_busy  = 1'b1;
            w_valid = 1'b1;
            if (r_ones == 3'd5) begin
               w_bit  = 1'b0;
               w_ones = 3'd0;
               if (r_cnt == 5'd16) begin
                  w_state = S_CLOSE;
                  w_cnt   = 5'd0;
               end
            end else begin
               // r_fcs doubles as the FCS shifter; the line carries its complement
               w_bit  = ~r_fcs[0];
               w_fcs  = {1'b1, r_fcs[15:1]};
               w_ones = ~r_fcs[0] ? r_ones + 3'd1 : 3'd0;
               w_cnt  = r_cnt + 5'd1;
               if (r_cnt == 5'd15) begin
                  if (!r_fcs[0] && r_ones == 3'd4) begin
                     w_cnt = 5'd16;
                  end else begin
                     w_state = S_CLOSE;
                     w_cnt   = 5'd0;
                  end
               end
            end
         end
         S_CLOSE: begin
            w_busy = 1'b1;
            w_bit  = FLAG[r_cnt[2:0]];
            w_cnt  = r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
               w_state     = S_IDLE;
               w_cnt       = 5'd0;
               w_close_end = 1'b1;
            end
         end
         S_ABORT: begin
            w_busy = 1'b1;
            w_abt  = 1'b1;
            w_bit  = (r_cnt != 5'd0);
            w_cnt  = r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
               w_state = S_IDLE;
               w_cnt   = 5'd0;
            end
         end
         default: w_state = S_IDLE;
      endcase
      if (Tx_AbortFrame && (r_state == S_OPEN || r_state == S_DATA || r_state == S_FCS)) begin
         w_state = S_ABORT;
         w_cnt   = 5'd0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_cnt       <= 5'd0;
         r_sh        <= 8'd0;
         r_fcs       <= 16'hFFFF;
         r_ones      <= 3'd0;
         r_len       <= 8'd0;
         r_byte      <= 8'd0;
         r_addr      <= 7'd0;
         r_tx        <= 1'b1;
         r_valid     <= 1'b0;
         r_abt       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_close_end <= 1'b0;
         r_size_err  <= 1'b0;
      end else begin
         r_cnt       <= w_cnt;
         r_sh        <= w_sh;
         r_fcs       <= w_fcs;
         r_ones      <= w_ones;
         r_len       <= w_len;
         r_byte      <= w_byte;
         r_addr      <= w_addr;
         r_tx        <= w_bit;
         r_valid     <= w_valid;
         r_abt       <= w_abt;
         r_busy      <= w_busy;
         r_done      <= r_close_end;
         r_close_end <= w_close_end;
         r_size_err  <= w_size_err;
      end
   end

   assign Tx_RdAddr       = r_addr;
   assign Tx              = r_tx;
   assign Tx_ValidFrame   = r_valid;
   assign Tx_AbortedTrans = r_abt;
   assign Tx_Busy         = r_busy;
   assign Tx_Done         = r_done;
   assign Tx_SizeErr      = r_size_err;

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Bench for hdlc_tx_sequencer: expected line bit streams built from whole frames (bytes -> CRC -> stuffing).
module tb_hdlc_tx_sequencer;

   logic       Clk = 1'b0;
   logic       Rst, Tx_Enable, Tx_AbortFrame;
   logic [7:0] Tx_FrameSize;
   logic [6:0] Tx_RdAddr;
   logic [7:0] Tx_RdData;
   logic       Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Busy, Tx_Done, Tx_SizeErr;

   logic [7:0] mem [0:127];
   bit   [2:0] exp_q [$];
   bit         rx_q [$];
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 Clk = ~Clk;
   always @(posedge Clk) Tx_RdData <= mem[Tx_RdAddr];

   hdlc_tx_sequencer #(.MAX_FRAME(128)) dut (
      .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
      .Tx_FrameSize(Tx_FrameSize), .Tx_RdAddr(Tx_RdAddr), .Tx_RdData(Tx_RdData),
      .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame), .Tx_AbortedTrans(Tx_AbortedTrans),
      .Tx_Busy(Tx_Busy), .Tx_Done(Tx_Done), .Tx_SizeErr(Tx_SizeErr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic [15:0] r;
      r = {1'b0, c[15:1]};
      if (c[0] ^ b) r = r ^ 16'h8408;
      return r;
   endfunction

   // {Tx, ValidFrame, AbortedTrans} per line bit for an uninterrupted frame of mem[0..n-1]
   task automatic build_stream(input int n);
      bit          cont [$];
      logic [15:0] crc;
      logic [15:0] fcs;
      logic [7:0]  flag;
      int          ones;
      exp_q.delete();
      crc  = 16'hFFFF;
      flag = 8'h7E;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 8; j++) begin
            cont.push_back(mem[i][j]);
            crc = crc_step(crc, mem[i][j]);
         end
      fcs = ~crc;
      for (int j = 0; j < 16; j++) cont.push_back(fcs[j]);
      for (int j = 0; j < 8; j++) exp_q.push_back({flag[j], 2'b00});
      ones = 0;
      foreach (cont[k]) begin
         exp_q.push_back({cont[k], 2'b10});
         ones = cont[k] ? ones + 1 : 0;
         if (ones == 5) begin
            exp_q.push_back(3'b010);
            ones = 0;
         end
      end
      for (int j = 0; j < 8; j++) exp_q.push_back({flag[j], 2'b00});
   endtask

   // Receiver view: strip stuffed zeros from the ValidFrame bits, recover bytes and test the FCS residue
   task automatic deframe(input int n);
      bit          d [$];
      int          ones;
      bit          skip;
      logic [15:0] crc;
      logic [7:0]  b;
      ones = 0;
      skip = 1'b0;
      crc  = 16'hFFFF;
      foreach (rx_q[k]) begin
         if (skip) begin
            skip = 1'b0;
            ones = 0;
         end else begin
            d.push_back(rx_q[k]);
            ones = rx_q[k] ? ones + 1 : 0;
            if (ones == 5) skip = 1'b1;
         end
      end
      check("rx_len", d.size(), 8 * n + 16);
      if (d.size() == 8 * n + 16) begin
         for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) b[j] = d[8 * i + j];
            check("rx_byte", b, mem[i]);
         end
         foreach (d[k]) crc = crc_step(crc, d[k]);
         check("rx_fcs_residue", crc, 16'hF0B8);
      end
   endtask

   task automatic run_frame(input int n, input int abort_t, input int en_t, input int rst_t);
      int len, vcnt, evcnt, run, maxrun;
      bit ab;
      build_stream(n);
      if (abort_t > 0) begin
         while (exp_q.size() > abort_t) void'(exp_q.pop_back());
         for (int j = 0; j < 8; j++) begin
            ab = (j != 0);
            exp_q.push_back({ab, 2'b01});
         end
      end
      if (rst_t > 0)
         while (exp_q.size() > rst_t - 1) void'(exp_q.pop_back());
      len    = exp_q.size();
      evcnt  = 0;
      foreach (exp_q[k]) if (exp_q[k][1]) evcnt++;
      rx_q.delete();
      vcnt   = 0;
      run    = 0;
      maxrun = 0;
      Tx_FrameSize = 8'(n);
      Tx_Enable    = 1'b1;
      step();
      Tx_Enable    = 1'b0;
      Tx_FrameSize = 8'($urandom);
      check("start_idle_bit", {Tx, Tx_Busy}, 2'b10);
      for (int e = 1; e <= len; e++) begin
         Tx_AbortFrame = (e == abort_t);
         Tx_Enable     = (e == en_t);
         if (e == en_t) Tx_FrameSize = 8'd5;
         step();
         check("line", {Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Busy, Tx_Done}, {exp_q[e-1], 2'b10});
         if (Tx_ValidFrame) begin
            rx_q.push_back(Tx);
            vcnt++;
            run = Tx ? run + 1 : 0;
         end else begin
            run = 0;
         end
         if (run > maxrun) maxrun = run;
      end
      Tx_AbortFrame = 1'b0;
      Tx_Enable     = 1'b0;
      if (rst_t > 0) begin
         Rst = 1'b1;
         step();
         Rst = 1'b0;
         check("rst_mid_frame", {Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Busy, Tx_Done, Tx_SizeErr, Tx_RdAddr},
               {1'b1, 5'b0, 7'd0});
         return;
      end
      step();
      check("frame_end", {Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Busy, Tx_Done}, {4'b1000, (abort_t == 0)});
      if (abort_t == 0) begin
         check("valid_cycles", vcnt, evcnt);
         check("six_ones_in_frame", (maxrun > 5), 0);
         deframe(n);
      end else begin
         step();
         check("abort_no_done", {Tx, Tx_Busy, Tx_Done}, 3'b100);
      end
   endtask

   task automatic size_reject(input logic [7:0] n);
      Tx_FrameSize = n;
      Tx_Enable    = 1'b1;
      step();
      Tx_Enable    = 1'b0;
      check("size_err_pulse", {Tx, Tx_Busy, Tx_SizeErr}, 3'b101);
      step();
      check("size_err_clear", {Tx, Tx_Busy, Tx_SizeErr}, 3'b100);
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++)
         mem[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
   endtask

   initial begin
      Rst           = 1'b1;
      Tx_Enable     = 1'b0;
      Tx_AbortFrame = 1'b0;
      Tx_FrameSize  = 8'd0;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      step();
      step();
      check("reset_state", {Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Busy, Tx_Done, Tx_SizeErr, Tx_RdAddr},
            {1'b1, 5'b0, 7'd0});
      Rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step();
         check("idle", {Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Busy, Tx_Done, Tx_SizeErr, Tx_RdAddr},
               {1'b1, 5'b0, 7'd0});
      end

      for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
      run_frame(9, 0, 0, 0);

      mem[0] = 8'hFF;
      mem[1] = 8'hFF;
      run_frame(2, 0, 0, 0);

      fill_random(4);
      run_frame(4, 19, 0, 0);
      fill_random(4);
      run_frame(4, 3, 0, 0);
      mem[0] = 8'h00;
      run_frame(1, 25, 0, 0);

      size_reject(8'd0);
      size_reject(8'd129);
      size_reject(8'd255);

      fill_random(6);
      run_frame(6, 0, 20, 0);

      for (int i = 0; i < 3; i++) mem[i] = 8'h00;
      run_frame(3, 0, 0, 40);
      mem[0] = 8'($urandom);
      run_frame(1, 0, 0, 0);

      for (int it = 0; it < 8; it++) begin
         int n;
         n = $urandom_range(1, 16);
         fill_random(n);
         run_frame(n, 0, 0, 0);
      end
      fill_random(128);
      run_frame(128, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
